// File: rtl/transmit_stream.sv
// Return-path sample streamer: decimates I/Q samples, buffers them and
// emits fixed-length byte packets over a valid/ready link.
module transmit_stream #(
  parameter int         FIFO_DEPTH     = 256,
  parameter int         PACKET_SAMPLES = 32,
  parameter logic [7:0] SOURCE         = 8'h02,
  parameter logic [7:0] DESTINATION    = 8'h00
) (
  input  logic                          ipClk,
  input  logic                          ipnReset,
  input  logic                          ipEnable,
  input  logic [15:0]                   ipDecimation,
  input  logic                          ipSample_Valid,
  input  logic [17:0]                   ipSample_I,
  input  logic [17:0]                   ipSample_Q,
  output logic                          opTx_SoP,
  output logic                          opTx_EoP,
  output logic [7:0]                    opTx_Source,
  output logic [7:0]                    opTx_Destination,
  output logic [7:0]                    opTx_Length,
  output logic [7:0]                    opTx_Data,
  output logic                          opTx_Valid,
  input  logic                          ipTx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   opFIFO_Used,
  output logic [15:0]                   opDropped,
  input  logic                          ipClearDropped
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [5:0]  LP_LAST  = 6'(PACKET_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_t;

  state_t        r_state;
  logic [15:0]   r_dec;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_used;
  logic [15:0]   r_dropped;
  logic [31:0]   r_word;
  logic [1:0]    r_beat;
  logic [5:0]    r_widx;
  logic          r_valid;
  logic          r_sop;
  logic          r_eop;

  logic w_keep;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_flush;
  logic w_xfer;
  logic w_last;
  logic w_ready_pkt;

  assign w_keep      = ipSample_Valid & ipEnable & (r_dec == 16'd0);
  assign w_full      = (r_used == LP_DEPTH);
  assign w_push      = w_keep & ~w_full;
  assign w_pop       = (r_state == S_LOAD);
  assign w_flush     = ~ipEnable & (r_state == S_IDLE);
  assign w_xfer      = r_valid & ipTx_Ready;
  assign w_last      = (r_widx == LP_LAST);
  assign w_ready_pkt = (32'(r_used) >= PACKET_SAMPLES);

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      r_dec <= '0;
    end else if (!ipEnable) begin
      r_dec <= '0;
    end else if (ipSample_Valid) begin
      r_dec <= (r_dec == 16'd0) ? ipDecimation : r_dec - 16'd1;
    end
  end

  always_ff @(posedge ipClk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {ipSample_I[17:2], ipSample_Q[17:2]};
    end
  end

  // Flush only happens in IDLE with sampling off, so it never meets a push
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_used <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_flush) begin
        r_rptr <= r_wptr;
        r_used <= '0;
      end else begin
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        r_used <= r_used + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      r_dropped <= '0;
    end else if (ipClearDropped) begin
      r_dropped <= '0;
    end else if (w_keep & w_full & ~&r_dropped) begin
      r_dropped <= r_dropped + 16'd1;
    end
  end

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_beat  <= '0;
      r_widx  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_ready_pkt && ipEnable) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_word  <= r_mem[r_rptr];
          r_beat  <= '0;
          r_valid <= 1'b1;
          r_sop   <= (r_widx == 6'd0);
          r_eop   <= 1'b0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_xfer) begin
            if (r_beat == 2'd3) begin
              r_valid <= 1'b0;
              r_sop   <= 1'b0;
              r_eop   <= 1'b0;
              if (w_last) begin
                r_widx  <= '0;
                r_state <= S_IDLE;
              end else begin
                r_widx  <= r_widx + 6'd1;
                r_state <= S_LOAD;
              end
            end else begin
              r_beat <= r_beat + 2'd1;
              r_word <= {r_word[23:0], 8'h00};
              r_sop  <= 1'b0;
              r_eop  <= (r_beat == 2'd2) & w_last;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign opTx_SoP         = r_sop;
  assign opTx_EoP         = r_eop;
  assign opTx_Source      = SOURCE;
  assign opTx_Destination = DESTINATION;
  assign opTx_Length      = 8'(4 * PACKET_SAMPLES);
  assign opTx_Data        = r_word[31:24];
  assign opTx_Valid       = r_valid;
  assign opFIFO_Used      = r_used;
  assign opDropped        = r_dropped;

endmodule
